prt_dprx_trn_ctl: RTL and testbench
===================================

// Module: prt_dprx_trn_ctl
//
// PURPOSE
// - Link-training sequencer for the DP RX training datapath (per-lane pattern checkers).
// - On a start request: programs the pattern (TPS) into the active lanes, waits a settle time,
//   evaluates per-lane match/error activity over a window, then reports per-lane lock and error counts.
// - Sits between the policy/DPCD layer and the per-lane training checkers.
//
// PARAMETERS
// P_LANES   4   number of physical lanes (1, 2 or 4)
// P_WIN_W   16  width of window and threshold counters
// P_SETTLE  64  settle cycles between lane config and evaluation (>=1)
//
// PORTS
// CLK_IN           in   1            clock
// RSTN_IN          in   1            reset, synchronous, active-low
// CTL_START_IN     in   1            start pulse; samples TPS/LANES/WIN/THR
// CTL_ABORT_IN     in   1            abort pulse
// CTL_TPS_IN       in   3            training pattern 1..4 (TPS1..TPS4); 0 invalid
// CTL_LANES_IN     in   3            active lanes: 1, 2 or 4
// CTL_WIN_IN       in   P_WIN_W      evaluation window, cycles
// CTL_THR_IN       in   P_WIN_W      match cycles required for lock
// LANE_MATCH_IN    in   P_LANES      per-lane match level, 1 = pattern matched this cycle
// LANE_ERR_IN      in   P_LANES      per-lane symbol error pulse
// LANE_SET_OUT     out  P_LANES      per-lane config load strobe
// LANE_TPS_OUT     out  3            pattern driven with LANE_SET_OUT
// STA_BUSY_OUT     out  1            1 while not IDLE
// STA_DONE_OUT     out  1            one-cycle pulse: evaluation complete
// STA_LOCK_OUT     out  P_LANES      per-lane lock result, held until next CFG/abort
// STA_ERR_OUT      out  P_LANES*8    per-lane 8-bit error count, lane i at [8i+:8]
//
// BEHAVIOUR
// - Reset (RSTN_IN=0 at a clock edge): state IDLE; all outputs 0; all counters/latches 0.
//   Reset mid-operation returns to IDLE with no DONE and no LANE_SET pulse.
// - All outputs registered. FSM states: IDLE, CFG, SETTLE, EVAL, DONE, ABRT.
// - IDLE: on CTL_START_IN=1 (CTL_ABORT_IN=0): latch TPS, LANES, WIN, THR.
//   - Valid request (TPS!=0, LANES in {1,2,4}, LANES<=P_LANES) -> CFG.
//   - Invalid request -> DONE (LOCK=0, ERR=0); no LANE_SET pulse.
//   - START and ABORT both 1 in IDLE: ABORT wins; START ignored, stays IDLE.
// - CFG (1 cycle): LANE_SET_OUT = mask of lanes 0..LANES-1; LANE_TPS_OUT = latched TPS;
//   clear match counters, ERR and LOCK. -> SETTLE.
// - SETTLE: P_SETTLE cycles; LANE_MATCH_IN/LANE_ERR_IN ignored. -> EVAL.
// - EVAL: max(WIN,1) cycles (WIN=0 treated as 1).
//   - Per active lane: match counter +1 on LANE_MATCH_IN, saturates at 2^P_WIN_W-1.
//   - ERR +1 on LANE_ERR_IN, saturates at 255. Inactive lanes never count.
//   - After the last EVAL cycle (its sample included) -> DONE.
// - DONE (1 cycle): STA_DONE_OUT=1; STA_LOCK_OUT[i] = active(i) && match_cnt[i] >= THR.
//   THR=0 -> every active lane locks. -> IDLE.
// - Timing: START sampled at edge t -> LANE_SET_OUT high in cycle t+1; EVAL runs cycles
//   t+2+P_SETTLE .. t+1+P_SETTLE+WIN; STA_DONE_OUT high in cycle t+2+P_SETTLE+WIN.
// - CTL_START_IN while busy: ignored. CTL_*_IN changes while busy: no effect (latched).
// - ABORT in CFG/SETTLE/EVAL/DONE: -> ABRT (1 cycle): LANE_SET_OUT = latched lane mask,
//   LANE_TPS_OUT=0 (stops checkers); LOCK cleared; no DONE pulse. -> IDLE.
// - LANE_SET_OUT and LANE_TPS_OUT are 0 in every state except CFG and ABRT.
// - STA_BUSY_OUT=1 in every state except IDLE.
//
// TESTING (bench P_LANES=4, P_SETTLE=4, P_WIN_W=16)
// - Start TPS=1, LANES=4, WIN=10, THR=8; MATCH=4'b1111 constant -> SET=4'b1111/TPS=1 at t+1,
//   DONE at t+16, LOCK=4'b1111, ERR all 0.
// - LANES=2, WIN=10, THR=8; lane1 MATCH low 3 EVAL cycles; 2 ERR pulses on lane0 ->
//   SET=4'b0011, LOCK=4'b0001, ERR lane0=2, lane1=0, lanes2/3=0.
// - Errors through SETTLE only, then clean -> ERR=0. ERR pulses every EVAL cycle,
//   WIN=300 -> ERR saturates at 255.
// - Invalid: LANES=3, TPS=0 or LANES=4 with P_LANES=2 -> no SET, DONE at t+1, LOCK=0.
// - ABORT in EVAL (LANES=4, TPS=3) -> next cycle SET=4'b1111 with TPS=0, no DONE,
//   LOCK=0, BUSY=0 after; START+ABORT same cycle in IDLE -> stays IDLE.
// - RSTN_IN low mid-SETTLE -> IDLE, all outputs 0; START during busy ignored;
//   WIN=0 -> one EVAL cycle, DONE at t+7; THR=0 -> LOCK=4'b1111 with MATCH=0.

Source files
------------

// File: rtl/prt_dprx_trn_ctl.sv
// prt_dprx_trn_ctl: DP RX link-training sequencer; programs lane checkers, settles,
// evaluates per-lane match/error activity over a window and reports lock and error counts.
module prt_dprx_trn_ctl #(
    parameter int P_LANES  = 4,
    parameter int P_WIN_W  = 16,
    parameter int P_SETTLE = 64
) (
    input  logic                   CLK_IN,
    input  logic                   RSTN_IN,
    input  logic                   CTL_START_IN,
    input  logic                   CTL_ABORT_IN,
    input  logic [2:0]             CTL_TPS_IN,
    input  logic [2:0]             CTL_LANES_IN,
    input  logic [P_WIN_W-1:0]     CTL_WIN_IN,
    input  logic [P_WIN_W-1:0]     CTL_THR_IN,
    input  logic [P_LANES-1:0]     LANE_MATCH_IN,
    input  logic [P_LANES-1:0]     LANE_ERR_IN,
    output logic [P_LANES-1:0]     LANE_SET_OUT,
    output logic [2:0]             LANE_TPS_OUT,
    output logic                   STA_BUSY_OUT,
    output logic                   STA_DONE_OUT,
    output logic [P_LANES-1:0]     STA_LOCK_OUT,
    output logic [P_LANES*8-1:0]   STA_ERR_OUT
);
    localparam int SW = $clog2(P_SETTLE + 1);
    localparam int CW = P_WIN_W > SW ? P_WIN_W : SW;

    typedef enum logic [2:0] {IDLE, CFG, SETTLE, EVAL, DONE, ABRT} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [2:0]           tps_q;
    logic [P_LANES-1:0]   mask_q, mask_in, lock_nxt;
    logic [P_WIN_W-1:0]   win_q, thr_q;
    logic [P_WIN_W-1:0]   mcnt [P_LANES];
    logic [P_WIN_W-1:0]   mcnt_nxt [P_LANES];
    logic [P_LANES*8-1:0] err_nxt;
    logic                 req, req_ok, clr;

    always_comb begin
        req = state == IDLE && CTL_START_IN && !CTL_ABORT_IN;
        req_ok = CTL_TPS_IN != 3'd0 && (CTL_LANES_IN == 3'd1 || CTL_LANES_IN == 3'd2 || CTL_LANES_IN == 3'd4)
                 && int'(CTL_LANES_IN) <= P_LANES;
        // Counters saturate; lanes outside the latched mask never advance
        for (int i = 0; i < P_LANES; i++) begin
            mask_in[i] = i < int'(CTL_LANES_IN);
            mcnt_nxt[i] = mcnt[i] + P_WIN_W'(mask_q[i] && LANE_MATCH_IN[i] && !(&mcnt[i]));
            err_nxt[8*i+:8] = STA_ERR_OUT[8*i+:8] + 8'(mask_q[i] && LANE_ERR_IN[i] && !(&STA_ERR_OUT[8*i+:8]));
            lock_nxt[i] = mask_q[i] && mcnt_nxt[i] >= thr_q;
        end
        state_nxt = state;
        cnt_nxt = cnt;
        case (state)
            IDLE:    state_nxt = req ? (req_ok ? CFG : DONE) : IDLE;
            CFG: begin
                state_nxt = CTL_ABORT_IN ? ABRT : SETTLE;
                cnt_nxt = CW'(P_SETTLE - 1);
            end
            SETTLE: begin
                state_nxt = CTL_ABORT_IN ? ABRT : (cnt == '0 ? EVAL : SETTLE);
                cnt_nxt = cnt == '0 ? CW'(win_q == '0 ? '0 : win_q - 1'b1) : cnt - 1'b1;
            end
            EVAL: begin
                state_nxt = CTL_ABORT_IN ? ABRT : (cnt == '0 ? DONE : EVAL);
                cnt_nxt = cnt - 1'b1;
            end
            DONE:    state_nxt = CTL_ABORT_IN ? ABRT : IDLE;
            default: state_nxt = IDLE;
        endcase
        clr = state == IDLE && state_nxt != IDLE;
    end

    // Outputs are registered from the next state so they align with the state they describe
    always_ff @(posedge CLK_IN) begin
        if (!RSTN_IN) begin
            state <= IDLE;
            cnt <= '0;
            tps_q <= '0;
            mask_q <= '0;
            win_q <= '0;
            thr_q <= '0;
            for (int i = 0; i < P_LANES; i++) mcnt[i] <= '0;
            LANE_SET_OUT <= '0;
            LANE_TPS_OUT <= '0;
            STA_BUSY_OUT <= 1'b0;
            STA_DONE_OUT <= 1'b0;
            STA_LOCK_OUT <= '0;
            STA_ERR_OUT <= '0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
            if (req) begin
                tps_q <= CTL_TPS_IN;
                mask_q <= req_ok ? mask_in : '0;
                win_q <= CTL_WIN_IN;
                thr_q <= CTL_THR_IN;
            end
            LANE_SET_OUT <= state_nxt == CFG ? mask_in : (state_nxt == ABRT ? mask_q : '0);
            LANE_TPS_OUT <= state_nxt == CFG ? CTL_TPS_IN : '0;
            STA_BUSY_OUT <= state_nxt != IDLE;
            STA_DONE_OUT <= state_nxt == DONE;
            STA_LOCK_OUT <= (clr || state_nxt == ABRT) ? '0 : (state == EVAL && state_nxt == DONE ? lock_nxt : STA_LOCK_OUT);
            STA_ERR_OUT <= clr ? '0 : (state == EVAL ? err_nxt : STA_ERR_OUT);
            for (int i = 0; i < P_LANES; i++) mcnt[i] <= clr ? '0 : (state == EVAL ? mcnt_nxt[i] : mcnt[i]);
        end
    end
endmodule

// File: tb/tb_prt_dprx_trn_ctl.sv
// tb_prt_dprx_trn_ctl: scoreboard bench for the link-training sequencer; stimulus queues
// expected SET/DONE/status events, a negedge monitor pops and compares them.
module tb_prt_dprx_trn_ctl;
    localparam int PL = 4;
    localparam int PW = 16;
    localparam int PS = 4;

    logic        clk = 1'b0, rstn = 1'b0, start = 1'b0, abort = 1'b0;
    logic [2:0]  tps = '0, lanes = '0;
    logic [15:0] win = '0, thr = '0;
    logic [3:0]  match = '0, err = '0;
    logic [3:0]  set_o, lock_o;
    logic [2:0]  tps_o;
    logic        busy_o, done_o;
    logic [31:0] err_o;

    prt_dprx_trn_ctl #(.P_LANES(PL), .P_WIN_W(PW), .P_SETTLE(PS)) dut (
        .CLK_IN(clk), .RSTN_IN(rstn), .CTL_START_IN(start), .CTL_ABORT_IN(abort),
        .CTL_TPS_IN(tps), .CTL_LANES_IN(lanes), .CTL_WIN_IN(win), .CTL_THR_IN(thr),
        .LANE_MATCH_IN(match), .LANE_ERR_IN(err), .LANE_SET_OUT(set_o), .LANE_TPS_OUT(tps_o),
        .STA_BUSY_OUT(busy_o), .STA_DONE_OUT(done_o), .STA_LOCK_OUT(lock_o), .STA_ERR_OUT(err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; logic [3:0] set; logic [2:0] tps;} set_t;
    typedef struct {int cyc; logic [3:0] lock; logic [31:0] err;} done_t;
    typedef struct {int cyc; logic busy; logic [3:0] lock; logic zero;} snap_t;

    set_t  set_q[$];
    done_t done_q[$];
    snap_t snap_q[$];
    int    n_cmp = 0, n_bad = 0;
    bit    fin = 1'b0;
    logic [3:0] exp_lock = '0;

    set_t  xs;
    done_t xd;
    snap_t xn;

    always @(negedge clk) begin
        if (set_o != '0 || tps_o != '0) begin
            n_cmp++;
            if (set_q.size() == 0) begin
                n_bad++;
                $display("FAIL set_extra cyc=%0d got set=%b tps=%0d want no set", cyc, set_o, tps_o);
            end else begin
                xs = set_q.pop_front();
                if (xs.cyc != cyc || xs.set != set_o || xs.tps != tps_o) begin
                    n_bad++;
                    $display("FAIL set cyc=%0d got set=%b tps=%0d want cyc=%0d set=%b tps=%0d",
                             cyc, set_o, tps_o, xs.cyc, xs.set, xs.tps);
                end
            end
        end
        if (set_q.size() != 0 && set_q[0].cyc < cyc) begin
            xs = set_q.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL set_missing got none want cyc=%0d set=%b tps=%0d", xs.cyc, xs.set, xs.tps);
        end
        if (done_o) begin
            n_cmp++;
            if (done_q.size() == 0) begin
                n_bad++;
                $display("FAIL done_extra cyc=%0d got done want none", cyc);
            end else begin
                xd = done_q.pop_front();
                if (xd.cyc != cyc || xd.lock != lock_o || xd.err != err_o) begin
                    n_bad++;
                    $display("FAIL done cyc=%0d got lock=%b err=%h want cyc=%0d lock=%b err=%h",
                             cyc, lock_o, err_o, xd.cyc, xd.lock, xd.err);
                end
            end
        end
        if (done_q.size() != 0 && done_q[0].cyc < cyc) begin
            xd = done_q.pop_front();
            n_cmp++; n_bad++;
            $display("FAIL done_missing got none want cyc=%0d lock=%b err=%h", xd.cyc, xd.lock, xd.err);
        end
        if (snap_q.size() != 0 && snap_q[0].cyc <= cyc) begin
            xn = snap_q.pop_front();
            n_cmp++;
            if (xn.cyc != cyc || busy_o != xn.busy || lock_o != xn.lock ||
                (xn.zero && (set_o != '0 || tps_o != '0 || done_o || err_o != '0))) begin
                n_bad++;
                $display("FAIL status cyc=%0d got busy=%b lock=%b set=%b tps=%0d done=%b err=%h want cyc=%0d busy=%b lock=%b zero=%b",
                         cyc, busy_o, lock_o, set_o, tps_o, done_o, err_o, xn.cyc, xn.busy, xn.lock, xn.zero);
            end
        end
        if (fin) begin
            n_cmp++;
            if (set_q.size() != 0 || done_q.size() != 0 || snap_q.size() != 0) begin
                n_bad++;
                $display("FAIL drain got set=%0d done=%0d status=%0d pending want 0", set_q.size(), done_q.size(), snap_q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
        if (cyc > 40000) begin
            $display("FAIL watchdog cyc=%0d want below 40000", cyc);
            $fatal(1, "watchdog expired");
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference: counts match/err bits over the EVAL cycles s+2+PS .. s+1+PS+max(WIN,1)
    task automatic run(input logic [2:0] t, input logic [2:0] l, input logic [15:0] w,
                       input logic [15:0] th, input int mode, input bit poke);
        logic ok;
        logic [3:0] act, mm, ee, lk;
        logic [31:0] er;
        int s, ew, len, j;
        int mc[4];
        int ec[4];
        logic [3:0] mq[$];
        logic [3:0] eq[$];
        bit ev;
        ok = t != 3'd0 && (l == 3'd1 || l == 3'd2 || l == 3'd4);
        act = !ok ? 4'b0000 : (l == 3'd1 ? 4'b0001 : (l == 3'd2 ? 4'b0011 : 4'b1111));
        ew = (w == 16'd0) ? 1 : int'(w);
        len = ok ? 2 + PS + ew : 1;
        for (int i = 0; i < 4; i++) begin mc[i] = 0; ec[i] = 0; end
        for (int k = 0; k <= len; k++) begin
            j = k - (2 + PS);
            ev = ok && j >= 0 && j < ew;
            case (mode)
                1: begin mm = 4'hf; ee = 4'h0; end
                2: begin mm = 4'hf; ee = (j < 0) ? 4'hf : 4'h0; end
                3: begin mm = 4'($urandom); ee = 4'hf; end
                4: begin mm = 4'h0; ee = 4'h0; end
                5: begin
                    mm = (ev && j >= 2 && j < 5) ? 4'b1101 : 4'hf;
                    ee = ((ev && (j == 1 || j == 7)) ? 4'b0001 : 4'b0000) | 4'b1100;
                end
                default: begin mm = 4'($urandom); ee = 4'($urandom) & 4'($urandom); end
            endcase
            mq.push_back(mm);
            eq.push_back(ee);
            if (ev)
                for (int i = 0; i < 4; i++)
                    if (act[i]) begin mc[i] += int'(mm[i]); ec[i] += int'(ee[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            lk[i] = act[i] && mc[i] >= int'(th);
            er[8*i +: 8] = 8'(ec[i] > 255 ? 255 : ec[i]);
        end
        s = cyc;
        if (ok) begin
            set_q.push_back('{s + 1, act, t});
            snap_q.push_back('{s + 2, 1'b1, 4'h0, 1'b0});
        end
        done_q.push_back('{s + len, lk, er});
        snap_q.push_back('{s + len + 1, 1'b0, lk, 1'b0});
        exp_lock = lk;
        for (int k = 0; k <= len; k++) begin
            start = k == 0 || (poke && ok && k == 3);
            tps   = k == 0 ? t  : 3'($urandom);
            lanes = k == 0 ? l  : 3'($urandom);
            win   = k == 0 ? w  : 16'($urandom);
            thr   = k == 0 ? th : 16'($urandom);
            match = mq[k];
            err   = eq[k];
            tick();
        end
        start = 1'b0;
    endtask

    task automatic run_abort(input int at);
        int s;
        s = cyc;
        set_q.push_back('{s + 1, 4'hf, 3'd3});
        set_q.push_back('{s + at + 1, 4'hf, 3'd0});
        snap_q.push_back('{s + at + 2, 1'b0, 4'h0, 1'b1});
        exp_lock = '0;
        for (int k = 0; k <= at; k++) begin
            start = k == 0;
            abort = k == at;
            tps   = k == 0 ? 3'd3 : 3'($urandom);
            lanes = k == 0 ? 3'd4 : 3'($urandom);
            win   = 16'd10;
            thr   = 16'd8;
            match = 4'hf;
            err   = 4'h0;
            tick();
        end
        start = 1'b0;
        abort = 1'b0;
        tick();
    endtask

    initial begin
        int sel;
        snap_q.push_back('{2, 1'b0, 4'h0, 1'b1});
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        run(3'd1, 3'd4, 16'd10, 16'd8, 1, 1'b0);
        run(3'd1, 3'd2, 16'd10, 16'd8, 5, 1'b0);
        run(3'd2, 3'd4, 16'd10, 16'd8, 2, 1'b1);
        run(3'd3, 3'd4, 16'd300, 16'd0, 3, 1'b0);
        run(3'd0, 3'd4, 16'd10, 16'd8, 0, 1'b0);
        run(3'd1, 3'd3, 16'd10, 16'd8, 0, 1'b0);
        run(3'd2, 3'd7, 16'd10, 16'd8, 0, 1'b0);
        run(3'd4, 3'd4, 16'd0, 16'd1, 1, 1'b0);
        run(3'd1, 3'd4, 16'd5, 16'd0, 4, 1'b0);
        run(3'd2, 3'd1, 16'd12, 16'd6, 0, 1'b1);
        run_abort(2 + PS + 3);
        run_abort(1);
        start = 1'b1; abort = 1'b1; tps = 3'd1; lanes = 3'd4; win = 16'd10; thr = 16'd1;
        snap_q.push_back('{cyc + 1, 1'b0, exp_lock, 1'b0});
        snap_q.push_back('{cyc + 2, 1'b0, exp_lock, 1'b0});
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        set_q.push_back('{cyc + 1, 4'hf, 3'd2});
        snap_q.push_back('{cyc + 4, 1'b0, 4'h0, 1'b1});
        snap_q.push_back('{cyc + 7, 1'b0, 4'h0, 1'b1});
        exp_lock = '0;
        start = 1'b1; tps = 3'd2; lanes = 3'd4; win = 16'd5; thr = 16'd1; match = 4'hf; err = 4'h0;
        tick();
        start = 1'b0;
        repeat (2) tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        repeat (3) tick();
        repeat (8) begin
            sel = int'($urandom_range(0, 4));
            run(3'($urandom_range(0, 4)),
                sel == 0 ? 3'd1 : (sel == 1 ? 3'd2 : (sel == 2 ? 3'd4 : 3'($urandom))),
                16'($urandom_range(0, 20)), 16'($urandom_range(0, 20)), 0, 1'b1);
        end
        fin = 1'b1;
        repeat (3) tick();
    end
endmodule
